// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the lsu_bus_master load/store unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - FSM state enumeration
//   - base byte-lane strobe patterns
//   - align_offset(): forces a byte offset to the size-aligned value
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Halves keep addr[1] only, words always start at lane 0.
    function automatic logic [1:0] align_offset(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [1:0] off;
        case (size)
            SZ_BYTE: off = addr_lo;
            SZ_HALF: off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the LSU.
//   size       in  2   normalized access size (SZ_*)
//   offset     in  2   size-aligned byte offset within the word
//   is_unsigned in 1   zero-extend instead of sign-extend loads
//   wdata      in  32  right-justified store data
//   rdata      in  32  raw memory word
//   strobe     out 4   byte write strobes
//   wdata_rep  out 32  store data replicated across lanes
//   rdata_ext  out 32  extracted and extended load data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;

    // Lane selection for stores and lane extraction plus extension for loads.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        strobe    = STRB_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SZ_BYTE: begin
                strobe    = STRB_BYTE << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h000000, shifted_s[7:0]}
                                        : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            SZ_HALF: begin
                strobe    = STRB_HALF << {offset[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0000, shifted_s[15:0]}
                                        : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            default: begin
                strobe    = STRB_WORD;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests
// into word-addressed memory bus cycles with byte strobes.
// Ports:
//   clk, rst (synchronous, active-high)
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata : core request
//   resp_valid/resp_rdata/resp_err : one-cycle completion to the core
//   RRdy/RVld/RAddr/RWEn/RWStrobe/RWData/RData : word-addressed memory port
// Parameters: ADDR_W (word address width), TIMEOUT (max LOAD wait cycles).
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses
// with an error response; otherwise misaligned low bits are forced aligned.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        RRdy,
    input  logic        RVld,
    output logic [31:0] RAddr,
    output logic        RWEn,
    output logic [3:0]  RWStrobe,
    output logic [31:0] RWData,
    input  logic [31:0] RData
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e        state_r, next_state_s;
    logic [1:0]        size_r, off_r;
    logic              uns_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [1:0]        in_size_s, in_off_s;
    logic              misalign_s, accept_s, last_wait_s;
    logic [1:0]        al_size_s, al_off_s;
    logic [3:0]        al_strobe_s;
    logic [31:0]       al_wdata_s, al_rdata_s;
    logic              resp_err_s;
    logic [31:0]       resp_rdata_s;
    logic              unused_s;

    assign unused_s    = ^req_addr[31:ADDR_W+2];
    assign accept_s    = (state_r == ST_IDLE) && req_ready && req_valid;
    assign last_wait_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Decode of the incoming request: size 3 behaves as word.
    always_comb begin
        in_size_s = (req_size == 2'd3) ? SZ_WORD : req_size;
        in_off_s  = align_offset(in_size_s, req_addr[1:0]);
`ifdef MISALIGN_TRAP_EN
        misalign_s = (in_off_s != req_addr[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // The lane aligner sees the live request while idle (store setup) and
    // the latched request otherwise (load extract).
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_size_s = in_size_s;
            al_off_s  = in_off_s;
        end else begin
            al_size_s = size_r;
            al_off_s  = off_r;
        end
    end

    lsu_lane_align u_align (
        .size        (al_size_s),
        .offset      (al_off_s),
        .is_unsigned (uns_r),
        .wdata       (req_wdata),
        .rdata       (RData),
        .strobe      (al_strobe_s),
        .wdata_rep   (al_wdata_s),
        .rdata_ext   (al_rdata_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (misalign_s)  next_state_s = ST_RESP;
                    else if (req_we) next_state_s = ST_STORE;
                    else             next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STORE: next_state_s = ST_RESP;
            ST_LOAD: begin
                if (RVld || last_wait_s) next_state_s = ST_RESP;
                else                     next_state_s = ST_LOAD;
            end
            ST_RESP:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Response payload for the transition into RESP.
    always_comb begin
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && misalign_s) resp_err_s = 1'b1;
                else                        resp_err_s = 1'b0;
            end
            ST_LOAD: begin
                if (RVld)             resp_rdata_s = al_rdata_s;
                else if (last_wait_s) resp_err_s   = 1'b1;
                else                  resp_err_s   = 1'b0;
            end
            default: begin
                resp_err_s   = 1'b0;
                resp_rdata_s = 32'h0000_0000;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= next_state_s;
    end

    // Registered outputs, decoded from the state being entered, plus request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b0;
            RRdy       <= 1'b0;
            RWEn       <= 1'b0;
            RWStrobe   <= 4'b0000;
            RWData     <= 32'h0000_0000;
            RAddr      <= 32'h0000_0000;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            size_r     <= SZ_BYTE;
            off_r      <= 2'b00;
            uns_r      <= 1'b0;
            cnt_r      <= '0;
        end else begin
            req_ready  <= (next_state_s == ST_IDLE);
            RRdy       <= (next_state_s == ST_LOAD);
            RWEn       <= (next_state_s == ST_STORE);
            RWStrobe   <= (next_state_s == ST_STORE) ? al_strobe_s : 4'b0000;
            RWData     <= (next_state_s == ST_STORE) ? al_wdata_s : 32'h0000_0000;
            resp_valid <= (next_state_s == ST_RESP);
            resp_err   <= (next_state_s == ST_RESP) ? resp_err_s : 1'b0;
            resp_rdata <= (next_state_s == ST_RESP) ? resp_rdata_s : 32'h0000_0000;
            if (accept_s) begin
                size_r <= in_size_s;
                off_r  <= in_off_s;
                uns_r  <= req_unsigned;
                RAddr  <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                cnt_r  <= '0;
            end else if (state_r == ST_LOAD) begin
                cnt_r  <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit sitting directly upstream of the word-addressed memory port (RRdy/RVld/RAddr/RWData/RWEn/RWStrobe/RData) of the lanzones core.
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests from the execute stage and converts them to word-address bus cycles with byte strobes.
- Returns sign- or zero-extended load data and a completion pulse to the core.

Parameters:
- ADDR_W, 16, width of word address driven on RAddr; upper RAddr bits are 0.
- TIMEOUT, 15, maximum LOAD cycles waiting for RVld before an error response.

Ports:
- clk  in  1  core clock, all flops rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  LSU can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned access or timeout, qualified by resp_valid.
- RRdy  out  1  read request to memory.
- RVld  in  1  memory read response valid.
- RAddr  out  32  word address = {0, req_addr[ADDR_W+1:2]}.
- RWEn  out  1  write enable, single cycle.
- RWStrobe  out  4  byte-lane write strobes.
- RWData  out  32  lane-replicated store data.
- RData  in  32  memory read data, valid with RVld.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0, except req_ready, which is 0 during reset and 1 in the first IDLE cycle after reset.
- FSM states: IDLE, STORE, LOAD, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, latch the request and lane offset (addr[1:0]).
  - Next state: STORE if we = 1, otherwise LOAD.
- STORE
  - RWEn = 1 for exactly one cycle. RRdy = 0.
  - RWStrobe: byte = 0001 << addr[1:0]; half = 0011 << {addr[1],1'b0}; word = 1111.
  - RWData: byte replicated ×4, half replicated ×2, word as-is.
  - Next state: RESP.
- LOAD
  - RRdy = 1 and RAddr is held until the cycle in which RVld = 1; RData is captured on that edge.
  - Memory returns RVld on the 2nd LOAD cycle. The LSU must tolerate any latency up to TIMEOUT.
  - Next state: RESP.
  - If the counter reaches TIMEOUT with no RVld, go to RESP with resp_err = 1 and rdata = 0.
- RESP
  - resp_valid = 1 for one cycle, then IDLE.
  - The core has no backpressure on resp_valid.
- Load extract (resp_rdata)
  - Byte: RData >> 8*addr[1:0].
  - Half: RData >> 16*addr[1].
  - Result is sign-extended unless req_unsigned.
- Latency from accept edge to resp_valid: store 2 cycles; load 3 cycles with the standard memory.
- Back-to-back requests: next accept in the cycle after RESP, so the minimum load period is 4 cycles.
- An RVld outside LOAD is ignored.
- rst mid-operation: FSM returns to IDLE, any in-flight bus cycle is abandoned (RRdy/RWEn drop next edge), and no resp_valid is issued.

Optional Feature:
- MISALIGN_TRAP_EN defined
  - Half with addr[0] = 1, or word with addr[1:0] ≠ 0, skips the bus cycle.
  - Goes IDLE→RESP with resp_err = 1 and rdata = 0.
  - No RWEn/RRdy is asserted.
- Undefined
  - Misaligned low address bits are forced to the size-aligned value: half uses addr[1] only, word uses offset 0.
  - Access proceeds normally with resp_err = 0 unless a timeout occurs.

Decomposition:
- lsu_pkg
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - Strobe constants.
- One combinational sub-module, lsu_lane_align
  - Strobe generation, store replication, and load extract/extend.
  - Instantiated once and shared by the STORE and RESP paths.

Test Plan:
- SW addr 0x400, wdata 0xDEADBEEF → RWEn pulse, RAddr 0x100, strobe 1111; mem[0x100] = 0xDEADBEEF; resp_valid 2 cycles after accept, err 0.
- SB addr 0x402, wdata 0x000000A5 onto mem[0x100] = 0x11223344 → strobe 0100, RWData 0xA5A5A5A5; mem = 0x11A53344.
- LB addr 0x403, mem[0x100] = 0x80FF0102 → resp_rdata 0xFFFFFF80; LBU gives 0x00000080; LHU addr 0x402 gives 0x000080FF; resp_valid 3 cycles after accept.
- Memory model modified to hold RVld low → resp_err = 1 after TIMEOUT (15) LOAD cycles, rdata 0; then a new LW completes normally.
- LH addr 0x401: MISALIGN_TRAP_EN → no RRdy, err = 1 one cycle after accept; without it → reads lanes [15:0], err 0.
- rst asserted in the 2nd LOAD cycle → RRdy = 0 next edge, no resp_valid, req_ready = 1 in the first IDLE cycle after release.
